adc_capture_ctrl: RTL and testbench
===================================

Name: adc_capture_ctrl

Overview:
Triggered acquisition sequencer for the dual-channel ADC sample streams.
- Arms on command and waits for a rising trigger edge.
- Skips a programmable number of samples, then captures a programmable number of (optionally decimated) A/B sample pairs.
- Emits the pairs as one AXI-Stream packet terminated by tlast.
- Sits between the ADC stream interface and the DMA/FIFO writer; reports busy/done/overrun status to the register block.

Parameters:
CNT_WIDTH, 16, width of delay and sample-count configuration/counters
DEC_WIDTH, 8, width of decimation configuration (factor = cfg_dec+1)

Ports:
aclk  in  1  system clock, all logic on rising edge
areset  in  1  synchronous active-high reset
arm  in  1  single-cycle start request; latches cfg_*
abort  in  1  single-cycle stop request
trig  in  1  trigger level, already synchronous to aclk
cfg_delay  in  CNT_WIDTH  samples skipped after trigger edge
cfg_count  in  CNT_WIDTH  decimated samples captured per packet
cfg_dec  in  DEC_WIDTH  decimation: keep 1 of every cfg_dec+1 samples
s_axis_a_tvalid  in  1  channel A sample valid
s_axis_a_tdata  in  16  channel A sample
s_axis_b_tvalid  in  1  channel B sample valid
s_axis_b_tdata  in  16  channel B sample
m_axis_tvalid  out  1  output beat valid
m_axis_tdata  out  32  {b[15:0], a[15:0]}
m_axis_tlast  out  1  final beat of packet
m_axis_tready  in  1  downstream ready
busy  out  1  state is ARMED, DELAY or CAPTURE
done  out  1  state is DONE
overrun  out  1  sticky: a sample was dropped in this capture
state  out  3  encoded FSM state for debug readback

Behaviour:
- Reset: state=IDLE; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0; busy=0, done=0, overrun=0; all counters 0; trig_q=0.
- Sample strobe: stb = s_axis_a_tvalid & s_axis_b_tvalid. Ports have no ready; input is never back-pressured.
- Trigger edge: edge = trig & ~trig_q. trig_q is registered every cycle in every state, so a trigger already high at arm does not fire.
- States: IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4.
- IDLE/DONE + arm:
  - Latch cfg_delay, cfg_count, cfg_dec; clear overrun.
  - If cfg_count==0, go to DONE with no beats.
  - Otherwise go to ARMED.
- ARMED + edge: go to DELAY if latched delay != 0, else CAPTURE. Edge on the arm cycle itself is not seen.
- DELAY:
  - Decrement delay counter on each stb.
  - stb while counter==1 moves to CAPTURE; that sample is skipped, and the next stb is the first capture candidate.
- CAPTURE, decimation:
  - dec_cnt resets to 0 on entry.
  - On stb with dec_cnt==0 the sample is kept; dec_cnt wraps at latched cfg_dec.
- CAPTURE, kept sample:
  - Decrement remaining count.
  - If output register empty or accepted this cycle (m_axis_tvalid & m_axis_tready), load the data register: tvalid=1 on the next cycle (latency 1), tlast=1 iff it is the final counted sample.
  - Otherwise drop the sample and set overrun. The dropped sample is still counted.
  - If the final sample is dropped, the packet has no tlast beat; overrun flags it.
- Output stability: tdata/tlast stay stable while tvalid & ~tready.
- CAPTURE -> DONE once the count is exhausted and the output register is empty (final beat accepted).
- DONE: done=1 until the next arm.
- Ignored events:
  - arm while busy.
  - edge outside ARMED.
  - stb in IDLE, ARMED and DONE.
- abort (any state): next cycle state=IDLE, tvalid=0, tlast=0, counters cleared; overrun retained. abort beats arm in the same cycle.
- Reset mid-capture behaves like abort but also clears overrun.
- Counters are unsigned, width CNT_WIDTH; max count 2^CNT_WIDTH-1, no wrap.

Decomposition:
- Shared package adc_ctrl_pkg: state enum encoding (IDLE..DONE), sample width (16), output packing order constant.
- One sub-module is natural: adc_capture_outreg (1-entry AXIS output register with load/accept/overrun-detect).
- FSM and counters stay in the top.

Test Plan:
- Basic capture: cfg_delay=0, count=4, dec=0, stb every cycle, tready=1, arm then trig rise → 4 beats on consecutive cycles, first beat 1 cycle after the first CAPTURE strobe, tlast on beat 4, done=1, overrun=0.
- Delay and decimation: delay=3, count=3, dec=1, A=incrementing 0,1,2… from the trigger cycle → first 3 skipped; beats carry A=3,5,7 (b packed in [31:16]); tlast on A=7.
- Backpressure:
  - tready=0 from beat 1, count=3, dec=0 → beat 1 held stable, samples 2 and 3 dropped, overrun=1, no tlast.
  - Then tready=1 → beat 1 accepted, done=1.
- Trigger handling:
  - trig held high before and during arm → no capture until trig falls and rises again.
  - Edges in IDLE and DONE → no effect.
- Abort and count=0:
  - abort mid-CAPTURE with tvalid=1 → next cycle tvalid=0, state=IDLE, busy=0.
  - arm with count=0 → DONE in 1 cycle, zero beats.
- Reset mid-DELAY → all outputs at reset values next cycle; a following arm/trigger capture completes normally.

Source files
------------

// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the ADC capture sequencer: FSM encoding, sample width, beat packing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adc_ctrl_pkg;

    localparam int SMP_W = 16;
    localparam int OUT_W = 2 * SMP_W;

    // Output beat packing: channel B in the upper half, channel A in the lower half.
    localparam bit PACK_B_HIGH = 1'b1;

    // Encoding is visible to software through the debug state readback.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    function automatic logic [OUT_W-1:0] pack_ab(input logic [SMP_W-1:0] a,
                                                 input logic [SMP_W-1:0] b);
        return PACK_B_HIGH ? {b, a} : {a, b};
    endfunction

endpackage

// File: rtl/adc_capture_outreg.sv
// One-entry AXI-Stream output register; reports a drop when a load finds it full and stalled.
// Latency: 1 cycle from load_req to m_axis_tvalid.
// Backpressure: holds tdata/tlast while tvalid & ~tready; a load that cannot be taken is discarded.
module adc_capture_outreg
    import adc_ctrl_pkg::*;
(
    input  logic             aclk,
    input  logic             areset,
    input  logic             flush,
    input  logic             load_req,
    input  logic [OUT_W-1:0] load_dat,
    input  logic             load_last,
    output logic             drop,
    output logic             m_axis_tvalid,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready
);

    logic             vld_q, vld_d;
    logic [OUT_W-1:0] dat_q, dat_d;
    logic             last_q, last_d;
    logic             can_load;

    // The slot is free if empty now or being drained this cycle.
    assign can_load = ~vld_q | m_axis_tready;

    // Next-state for the slot: drain on accept, refill on load, drop when stalled, flush wins.
    always_comb begin
        vld_d  = vld_q;
        dat_d  = dat_q;
        last_d = last_q;
        drop   = 1'b0;
        if (vld_q && m_axis_tready) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
        if (load_req) begin
            if (can_load) begin
                vld_d  = 1'b1;
                dat_d  = load_dat;
                last_d = load_last;
            end else begin
                drop = 1'b1;
            end
        end
        if (flush) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
    end

    // Slot registers; tdata is only cleared by reset, a flush just invalidates it.
    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_q  <= 1'b0;
            dat_q  <= '0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            last_q <= last_d;
        end
    end

    assign m_axis_tvalid = vld_q;
    assign m_axis_tdata  = dat_q;
    assign m_axis_tlast  = last_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered capture sequencer: arm, wait for trigger edge, skip delay, emit decimated A/B pairs as one packet.
// Latency: a kept sample appears on m_axis one cycle after its strobe.
// Backpressure: inputs are never stalled; a kept sample meeting a stalled output is dropped and flags overrun.
module adc_capture_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int DEC_WIDTH = 8
)
(
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 trig,
    input  logic [CNT_WIDTH-1:0] cfg_delay,
    input  logic [CNT_WIDTH-1:0] cfg_count,
    input  logic [DEC_WIDTH-1:0] cfg_dec,
    input  logic                 s_axis_a_tvalid,
    input  logic [15:0]          s_axis_a_tdata,
    input  logic                 s_axis_b_tvalid,
    input  logic [15:0]          s_axis_b_tdata,
    output logic                 m_axis_tvalid,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [2:0]           state
);

    state_e               state_q, state_d;
    logic                 trig_q;
    logic [CNT_WIDTH-1:0] delay_cnt_q, delay_cnt_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [DEC_WIDTH-1:0] dec_q, dec_d;
    logic [DEC_WIDTH-1:0] dec_cnt_q, dec_cnt_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 stb;
    logic                 edge_det;
    logic                 load_req;
    logic                 load_last;
    logic                 drop;
    logic                 clr_overrun;
    logic [OUT_W-1:0]     smp_dat;

    assign stb      = s_axis_a_tvalid & s_axis_b_tvalid;
    assign edge_det = trig & ~trig_q;
    assign smp_dat  = pack_ab(s_axis_a_tdata, s_axis_b_tdata);

    // Sequencer: state, delay/count/decimation counters and the load request to the output slot.
    always_comb begin
        state_d     = state_q;
        delay_cnt_d = delay_cnt_q;
        count_d     = count_q;
        dec_d       = dec_q;
        dec_cnt_d   = dec_cnt_q;
        load_req    = 1'b0;
        load_last   = 1'b0;
        clr_overrun = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    delay_cnt_d = cfg_delay;
                    count_d     = cfg_count;
                    dec_d       = cfg_dec;
                    dec_cnt_d   = '0;
                    clr_overrun = 1'b1;
                    state_d     = (cfg_count == '0) ? ST_DONE : ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (edge_det) begin
                    dec_cnt_d = '0;
                    state_d   = (delay_cnt_q != '0) ? ST_DELAY : ST_CAPTURE;
                end
            end
            ST_DELAY: begin
                // The strobe that takes the counter from 1 to 0 is itself skipped.
                if (stb) begin
                    delay_cnt_d = delay_cnt_q - CNT_WIDTH'(1);
                    if (delay_cnt_q == CNT_WIDTH'(1)) begin
                        dec_cnt_d = '0;
                        state_d   = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (stb && (count_q != '0)) begin
                    dec_cnt_d = (dec_cnt_q == dec_q) ? '0 : dec_cnt_q + DEC_WIDTH'(1);
                    // Dropped samples still consume the count, so the packet length stays bounded.
                    if (dec_cnt_q == '0) begin
                        load_req  = 1'b1;
                        load_last = (count_q == CNT_WIDTH'(1));
                        count_d   = count_q - CNT_WIDTH'(1);
                    end
                end
                if ((count_q == '0) && (!m_axis_tvalid || m_axis_tready)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            delay_cnt_d = '0;
            count_d     = '0;
            dec_d       = '0;
            dec_cnt_d   = '0;
            load_req    = 1'b0;
            load_last   = 1'b0;
            clr_overrun = 1'b0;
        end
    end

    // Sticky overrun: cleared by a fresh arm, set by any dropped sample, kept across abort.
    always_comb begin
        overrun_d = overrun_q;
        if (clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    // Status flags follow the next state so they are registered alongside it.
    always_comb begin
        busy_d = (state_d == ST_ARMED) || (state_d == ST_DELAY) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    // Sequencer registers; trig_q samples every cycle so a level already high at arm never fires.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            trig_q      <= 1'b0;
            delay_cnt_q <= '0;
            count_q     <= '0;
            dec_q       <= '0;
            dec_cnt_q   <= '0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_q      <= trig;
            delay_cnt_q <= delay_cnt_d;
            count_q     <= count_d;
            dec_q       <= dec_d;
            dec_cnt_q   <= dec_cnt_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    adc_capture_outreg u_outreg (
        .aclk          (aclk),
        .areset        (areset),
        .flush         (abort),
        .load_req      (load_req),
        .load_dat      (smp_dat),
        .load_last     (load_last),
        .drop          (drop),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;
    assign state   = state_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: directed scenarios plus randomized captures against a packet model.
// Latency: n/a.
// Backpressure: bench drives tready directly.
module tb_adc_capture_ctrl;

    logic        aclk = 1'b0;
    logic        areset, arm, abort, trig;
    logic [15:0] cfg_delay, cfg_count;
    logic [7:0]  cfg_dec;
    logic        a_vld, b_vld;
    logic [15:0] a_dat, b_dat;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        busy, done, overrun;
    logic [2:0]  state;

    int tests  = 0;
    int failed = 0;

    // Beats seen on m_axis as {tlast, tdata}, in order of acceptance.
    logic [32:0] got[$];

    logic        hold_prev = 1'b0;
    logic [31:0] prev_dat;
    logic        prev_last;

    adc_capture_ctrl #(.CNT_WIDTH(16), .DEC_WIDTH(8)) dut (
        .aclk            (aclk),
        .areset          (areset),
        .arm             (arm),
        .abort           (abort),
        .trig            (trig),
        .cfg_delay       (cfg_delay),
        .cfg_count       (cfg_count),
        .cfg_dec         (cfg_dec),
        .s_axis_a_tvalid (a_vld),
        .s_axis_a_tdata  (a_dat),
        .s_axis_b_tvalid (b_vld),
        .s_axis_b_tdata  (b_dat),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .busy            (busy),
        .done            (done),
        .overrun         (overrun),
        .state           (state)
    );

    always #5 aclk = ~aclk;

    // Output monitor on the falling edge: records handshakes and checks a stalled beat does not change.
    always @(negedge aclk) begin
        if (hold_prev) begin
            tests++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_dat || m_axis_tlast !== prev_last) begin
                failed++;
                $display("FAIL stall_stable got v=%0b d=%h l=%0b exp v=1 d=%h l=%0b",
                         m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_dat, prev_last);
            end
        end
        hold_prev = m_axis_tvalid && !m_axis_tready && !abort && !areset;
        prev_dat  = m_axis_tdata;
        prev_last = m_axis_tlast;
        if (m_axis_tvalid === 1'b1 && m_axis_tready && !abort && !areset)
            got.push_back({m_axis_tlast, m_axis_tdata});
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_sample(input int pct);
        a_vld = ($urandom_range(0, 99) < pct);
        b_vld = a_vld ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
        a_dat = 16'($urandom);
        b_dat = 16'($urandom);
    endtask

    // Arms, fires one trigger edge, then streams random samples until done; the packet expected is
    // derived from the strobe list: skip dly strobes, then every (dec+1)-th strobe, cnt of them.
    task automatic run_capture(input int dly, input int cnt, input int dec, input int pct);
        logic [31:0] smp[$];
        logic [32:0] exp_q[$];
        int          kept;
        bit          fin;
        got.delete();
        cfg_delay = 16'(dly); cfg_count = 16'(cnt); cfg_dec = 8'(dec);
        m_axis_tready = 1'b1;
        trig = 1'b0; arm = 1'b1; drive_sample(pct); tick();
        arm = 1'b0;
        repeat ($urandom_range(0, 3)) begin drive_sample(pct); tick(); end
        trig = 1'b1; drive_sample(pct); tick();
        fin = 1'b0;
        for (int c = 0; c < 600 && !fin; c++) begin
            drive_sample(pct);
            if (a_vld && b_vld) smp.push_back({b_dat, a_dat});
            if ($urandom_range(0, 3) == 0) trig = ~trig;
            tick();
            if (done === 1'b1) fin = 1'b1;
        end
        a_vld = 1'b0; b_vld = 1'b0;
        tests++;
        if (!fin) begin
            failed++;
            $display("FAIL rand_timeout dly=%0d cnt=%0d dec=%0d got done=%0b exp done=1", dly, cnt, dec, done);
        end
        kept = 0;
        for (int k = 0; k < smp.size(); k++) begin
            if (k >= dly && ((k - dly) % (dec + 1)) == 0 && kept < cnt) begin
                exp_q.push_back({(kept == cnt - 1), smp[k]});
                kept++;
            end
        end
        tests++;
        if (got.size() != exp_q.size()) begin
            failed++;
            $display("FAIL rand_beats dly=%0d cnt=%0d dec=%0d got %0d beats exp %0d", dly, cnt, dec, got.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                tests++;
                if (got[k] !== exp_q[k]) begin
                    failed++;
                    $display("FAIL rand_beat%0d got=%h exp=%h", k, got[k], exp_q[k]);
                end
            end
        end
        tests++;
        if (overrun !== 1'b0 || state !== 3'd4) begin
            failed++;
            $display("FAIL rand_end got ovr=%0b st=%0d exp ovr=0 st=4", overrun, state);
        end
    endtask

    task automatic check_reset_values(input string tag);
        tests++;
        if (state !== 3'd0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'h0 ||
            busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
            failed++;
            $display("FAIL %s got st=%0d v=%0b l=%0b d=%h busy=%0b done=%0b ovr=%0b exp all zero",
                     tag, state, m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, done, overrun);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0;
        cfg_delay = '0; cfg_count = '0; cfg_dec = '0;
        a_vld = 1'b0; b_vld = 1'b0; a_dat = '0; b_dat = '0; m_axis_tready = 1'b1;
        tick(); tick();
        check_reset_values("reset");
        areset = 1'b0;
        tick();
        check_reset_values("reset_idle");
    endtask

    task automatic test_basic();
        logic [31:0] e;
        cfg_delay = 16'd0; cfg_count = 16'd4; cfg_dec = 8'd0; m_axis_tready = 1'b1;
        trig = 1'b0; a_vld = 1'b1; b_vld = 1'b1; a_dat = 16'hFFFF; b_dat = 16'hFFFF;
        arm = 1'b1; tick(); arm = 1'b0;
        tests++;
        if (state !== 3'd1 || busy !== 1'b1) begin
            failed++; $display("FAIL basic_armed got st=%0d busy=%0b exp st=1 busy=1", state, busy);
        end
        trig = 1'b1; tick();
        tests++;
        if (state !== 3'd3 || m_axis_tvalid !== 1'b0) begin
            failed++; $display("FAIL basic_capture got st=%0d v=%0b exp st=3 v=0", state, m_axis_tvalid);
        end
        for (int i = 0; i < 4; i++) begin
            a_dat = 16'(i); b_dat = 16'h8000 + 16'(i);
            tick();
            e = {16'h8000 + 16'(i), 16'(i)};
            tests++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== e || m_axis_tlast !== (i == 3)) begin
                failed++;
                $display("FAIL basic_beat%0d got v=%0b d=%h l=%0b exp v=1 d=%h l=%0b",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, e, (i == 3));
            end
        end
        a_vld = 1'b0; b_vld = 1'b0;
        tick();
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || m_axis_tvalid !== 1'b0 || overrun !== 1'b0 || state !== 3'd4) begin
            failed++;
            $display("FAIL basic_done got done=%0b busy=%0b v=%0b ovr=%0b st=%0d exp 1 0 0 0 4",
                     done, busy, m_axis_tvalid, overrun, state);
        end
        trig = 1'b0;
    endtask

    task automatic test_delay_dec();
        logic [32:0] e;
        got.delete();
        cfg_delay = 16'd3; cfg_count = 16'd3; cfg_dec = 8'd1; m_axis_tready = 1'b1;
        trig = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0; tick();
        trig = 1'b1; tick();
        tests++;
        if (state !== 3'd2) begin
            failed++; $display("FAIL dd_delay_state got st=%0d exp 2", state);
        end
        for (int i = 0; i < 12; i++) begin
            a_dat = 16'(i); b_dat = 16'h4000 + 16'(i); a_vld = 1'b1; b_vld = 1'b1;
            tick();
        end
        a_vld = 1'b0; b_vld = 1'b0; tick();
        tests++;
        if (got.size() != 3) begin
            failed++; $display("FAIL dd_beats got %0d beats exp 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                e = {(k == 2), 16'h4000 + 16'(3 + 2 * k), 16'(3 + 2 * k)};
                tests++;
                if (got[k] !== e) begin
                    failed++; $display("FAIL dd_beat%0d got=%h exp=%h", k, got[k], e);
                end
            end
        end
        tests++;
        if (done !== 1'b1 || overrun !== 1'b0) begin
            failed++; $display("FAIL dd_done got done=%0b ovr=%0b exp 1 0", done, overrun);
        end
        trig = 1'b0;
    endtask

    task automatic test_backpressure();
        got.delete();
        cfg_delay = 16'd0; cfg_count = 16'd3; cfg_dec = 8'd0; m_axis_tready = 1'b0;
        trig = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        tests++;
        if (overrun !== 1'b0) begin
            failed++; $display("FAIL bp_arm_clear got ovr=%0b exp 0", overrun);
        end
        trig = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            a_dat = 16'(10 + i); b_dat = 16'h2000 + 16'(10 + i); a_vld = 1'b1; b_vld = 1'b1;
            tick();
        end
        a_vld = 1'b0; b_vld = 1'b0;
        tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h200A_000A || m_axis_tlast !== 1'b0 ||
            overrun !== 1'b1 || state !== 3'd3) begin
            failed++;
            $display("FAIL bp_stall got v=%0b d=%h l=%0b ovr=%0b st=%0d exp 1 200a000a 0 1 3",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, overrun, state);
        end
        repeat (3) tick();
        tests++;
        if (state !== 3'd3 || busy !== 1'b1) begin
            failed++; $display("FAIL bp_wait got st=%0d busy=%0b exp 3 1", state, busy);
        end
        m_axis_tready = 1'b1; tick();
        tests++;
        if (done !== 1'b1 || m_axis_tvalid !== 1'b0 || overrun !== 1'b1) begin
            failed++; $display("FAIL bp_done got done=%0b v=%0b ovr=%0b exp 1 0 1", done, m_axis_tvalid, overrun);
        end
        tests++;
        if (got.size() != 1 || got[0] !== {1'b0, 32'h200A_000A}) begin
            failed++; $display("FAIL bp_packet got %0d beats first=%h exp 1 beat %h", got.size(),
                               (got.size() > 0) ? got[0] : 33'h0, {1'b0, 32'h200A_000A});
        end
        abort = 1'b1; tick(); abort = 1'b0;
        tests++;
        if (state !== 3'd0 || overrun !== 1'b1 || done !== 1'b0) begin
            failed++; $display("FAIL bp_abort_keep_ovr got st=%0d ovr=%0b done=%0b exp 0 1 0", state, overrun, done);
        end
        trig = 1'b0;
    endtask

    task automatic test_trigger();
        got.delete();
        m_axis_tready = 1'b1;
        trig = 1'b1; drive_sample(100); tick(); tick();
        tests++;
        if (state !== 3'd0 || m_axis_tvalid !== 1'b0) begin
            failed++; $display("FAIL trig_idle_edge got st=%0d v=%0b exp 0 0", state, m_axis_tvalid);
        end
        cfg_delay = 16'd0; cfg_count = 16'd2; cfg_dec = 8'd0;
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (4) begin drive_sample(100); tick(); end
        tests++;
        if (state !== 3'd1 || m_axis_tvalid !== 1'b0) begin
            failed++; $display("FAIL trig_high_at_arm got st=%0d v=%0b exp 1 0", state, m_axis_tvalid);
        end
        trig = 1'b0; tick();
        trig = 1'b1; tick();
        tests++;
        if (state !== 3'd3) begin
            failed++; $display("FAIL trig_refire got st=%0d exp 3", state);
        end
        for (int c = 0; c < 40 && done !== 1'b1; c++) begin drive_sample(70); tick(); end
        a_vld = 1'b0; b_vld = 1'b0;
        tests++;
        if (done !== 1'b1 || got.size() != 2 || got[got.size() - 1][32] !== 1'b1) begin
            failed++; $display("FAIL trig_capture got done=%0b beats=%0d exp done=1 beats=2 with tlast", done, got.size());
        end
        for (int i = 0; i < 6; i++) begin trig = ~trig; drive_sample(100); tick(); end
        tests++;
        if (state !== 3'd4 || got.size() != 2 || m_axis_tvalid !== 1'b0) begin
            failed++; $display("FAIL trig_done_edges got st=%0d beats=%0d v=%0b exp 4 2 0", state, got.size(), m_axis_tvalid);
        end
        a_vld = 1'b0; b_vld = 1'b0; trig = 1'b0;
    endtask

    task automatic test_abort_count0();
        got.delete();
        cfg_delay = 16'd0; cfg_count = 16'd2; cfg_dec = 8'd0; m_axis_tready = 1'b1;
        abort = 1'b1; arm = 1'b1; tick(); abort = 1'b0; arm = 1'b0;
        tests++;
        if (state !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failed++; $display("FAIL abort_beats_arm got st=%0d busy=%0b done=%0b exp 0 0 0", state, busy, done);
        end
        cfg_count = 16'd5;
        arm = 1'b1; tick(); arm = 1'b0;
        trig = 1'b1; tick();
        a_dat = 16'h1234; b_dat = 16'h5678; a_vld = 1'b1; b_vld = 1'b1; tick();
        tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h5678_1234) begin
            failed++; $display("FAIL abort_pre got v=%0b d=%h exp 1 56781234", m_axis_tvalid, m_axis_tdata);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        tests++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || state !== 3'd0 || busy !== 1'b0) begin
            failed++; $display("FAIL abort_capture got v=%0b l=%0b st=%0d busy=%0b exp 0 0 0 0",
                               m_axis_tvalid, m_axis_tlast, state, busy);
        end
        trig = 1'b0; tick(); trig = 1'b1; tick(); tick();
        tests++;
        if (state !== 3'd0 || m_axis_tvalid !== 1'b0) begin
            failed++; $display("FAIL abort_idle_edge got st=%0d v=%0b exp 0 0", state, m_axis_tvalid);
        end
        cfg_count = 16'd0;
        arm = 1'b1; tick(); arm = 1'b0;
        tests++;
        if (state !== 3'd4 || done !== 1'b1 || busy !== 1'b0) begin
            failed++; $display("FAIL count0 got st=%0d done=%0b busy=%0b exp 4 1 0", state, done, busy);
        end
        for (int i = 0; i < 6; i++) begin trig = ~trig; drive_sample(100); tick(); end
        tests++;
        if (got.size() != 0 || m_axis_tvalid !== 1'b0 || state !== 3'd4) begin
            failed++; $display("FAIL count0_nobeats got beats=%0d v=%0b st=%0d exp 0 0 4", got.size(), m_axis_tvalid, state);
        end
        a_vld = 1'b0; b_vld = 1'b0; trig = 1'b0;
    endtask

    task automatic test_reset_mid_delay();
        cfg_delay = 16'd5; cfg_count = 16'd2; cfg_dec = 8'd0; m_axis_tready = 1'b1;
        trig = 1'b0; arm = 1'b1; tick(); arm = 1'b0;
        trig = 1'b1; tick();
        a_vld = 1'b1; b_vld = 1'b1; tick(); tick();
        tests++;
        if (state !== 3'd2) begin
            failed++; $display("FAIL rst_delay_state got st=%0d exp 2", state);
        end
        areset = 1'b1; tick();
        check_reset_values("rst_mid_delay");
        areset = 1'b0; trig = 1'b0; a_vld = 1'b0; b_vld = 1'b0; tick();
        run_capture(1, 3, 1, 80);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++)
            run_capture($urandom_range(0, 6), $urandom_range(1, 10), $urandom_range(0, 3), $urandom_range(40, 100));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delay_dec();
        test_backpressure();
        test_trigger();
        test_abort_count0();
        test_reset_mid_delay();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #600000;
        failed++;
        $display("FAIL global_timeout got still running exp finished");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1, "timeout");
    end

endmodule
